// File: rtl/alu_sequencer.sv
// Four-state instruction sequencer (IDLE/DECODE/EXEC/WB) driving the ALU/register-file
// datapath: decodes 16-bit words, strobes a single-cycle writeback and latches ALU flags.
module alu_sequencer #(
  parameter int unsigned                  OPCODE_WIDTH = 4,
  parameter logic [OPCODE_WIDTH-1:0]      CMP_OPCODE   = OPCODE_WIDTH'(4'hB),
  parameter int unsigned                  FLAG_WIDTH   = 5
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [15:0]             instr,
  input  logic                    instr_valid,
  output logic                    instr_ready,
  output logic [2:0]              a_reg,
  output logic [2:0]              b_reg,
  output logic [2:0]              dest_reg,
  output logic [15:0]             immediate,
  output logic                    immediate_p,
  output logic [OPCODE_WIDTH-1:0] alu_op,
  output logic                    reg_we,
  input  logic [FLAG_WIDTH-1:0]   alu_flags,
  output logic [FLAG_WIDTH-1:0]   flags,
  output logic                    busy,
  output logic                    done
);

  localparam int unsigned OP_EXT_W = (OPCODE_WIDTH > 4) ? OPCODE_WIDTH : 4;

  typedef enum logic [1:0] {IDLE, DECODE, EXEC, WB} state_t;

  state_t                  state_q, state_d;
  logic [2:0]              a_reg_q, b_reg_q, dest_reg_q;
  logic [15:0]             imm_q;
  logic                    imm_p_q;
  logic [OPCODE_WIDTH-1:0] alu_op_q;
  logic [FLAG_WIDTH-1:0]   flags_q;
  logic [OP_EXT_W-1:0]     op_ext;
  logic                    accept;

  assign accept = (state_q == IDLE) && instr_valid;
  assign op_ext = OP_EXT_W'(instr[14:11]);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = DECODE;
      DECODE:  state_d = EXEC;
      EXEC:    state_d = WB;
      WB:      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // The captured word is held directly in decoded form, so the decode outputs are
  // already stable in DECODE and hold unchanged through EXEC, WB and the following IDLE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_reg_q    <= '0;
      b_reg_q    <= '0;
      dest_reg_q <= '0;
      imm_q      <= '0;
      imm_p_q    <= 1'b0;
      alu_op_q   <= '0;
    end else if (accept) begin
      a_reg_q    <= instr[7:5];
      dest_reg_q <= instr[10:8];
      imm_p_q    <= instr[15];
      b_reg_q    <= instr[15] ? 3'b000 : instr[2:0];
      imm_q      <= instr[15] ? {{11{instr[4]}}, instr[4:0]} : 16'h0000;
      alu_op_q   <= op_ext[OPCODE_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                flags_q <= '0;
    else if (state_q == EXEC)  flags_q <= alu_flags;
  end

  assign instr_ready = reset && (state_q == IDLE);
  assign busy        = (state_q != IDLE);
  assign done        = (state_q == WB);
  assign reg_we      = (state_q == WB) && (alu_op_q != CMP_OPCODE);
  assign a_reg       = a_reg_q;
  assign b_reg       = b_reg_q;
  assign dest_reg    = dest_reg_q;
  assign immediate   = imm_q;
  assign immediate_p = imm_p_q;
  assign alu_op      = alu_op_q;
  assign flags       = flags_q;

endmodule
